// File: rtl/serial_adder_if.sv
// rtl/serial_adder_if.sv - request/result bundle for the bit-serial adder
//
// Purpose: groups the operand request and the registered result of
// serial_adder so the requester and the adder connect through one port.
//
// Signals:
//   start  requester -> adder  request, sampled by the adder in IDLE or DONE
//   a, b   requester -> adder  WIDTH-bit operands, captured on the accepting edge
//   c_in   requester -> adder  initial carry, captured on the accepting edge
//   busy   adder -> requester  high while bits are being processed
//   done   adder -> requester  one-cycle pulse, result just updated
//   sum    adder -> requester  WIDTH-bit result, held until the next completion
//   c_out  adder -> requester  carry out of bit WIDTH-1
//   ovf    adder -> requester  two's-complement overflow of the addition
//
// Modports: master = requester side, slave = adder side.

interface serial_adder_if #(
  parameter int WIDTH = 8
);

  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             c_in;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             c_out;
  logic             ovf;

  modport master (
    output start, a, b, c_in,
    input  busy, done, sum, c_out, ovf
  );

  modport slave (
    input  start, a, b, c_in,
    output busy, done, sum, c_out, ovf
  );

endinterface

// File: rtl/serial_adder.sv
// rtl/serial_adder.sv - bit-serial adder around a single full-adder cell
//
// Purpose: adds two WIDTH-bit operands plus a carry-in one bit per cycle,
// LSB first, through one 1-bit full-adder cell. The cell sum bit is shifted
// into a work register and its carry-out is fed back through a carry
// flip-flop. A result takes WIDTH cycles; back-to-back requests give one
// result every WIDTH+1 cycles.
//
// Ports:
//   clk    rising-edge clock
//   rst_n  synchronous active-low reset; discards any operation in flight
//   bus    serial_adder_if slave modport:
//            start/a/b/c_in in, busy/done/sum/c_out/ovf out
//
// Parameters:
//   WIDTH  operand/result width, 2..32

module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  serial_adder_if.slave   bus
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ADD  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  logic [WIDTH-1:0] work_q, work_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             carry_q, carry_d;
  logic             c_out_q, c_out_d;
  logic             ovf_q, ovf_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic             cell_s;
  logic             cell_co;

  // The one full-adder cell: current operand bits plus the registered carry.
  always_comb begin
    cell_s  = a_sh_q[0] ^ b_sh_q[0] ^ carry_q;
    cell_co = (a_sh_q[0] & b_sh_q[0]) | (carry_q & (a_sh_q[0] ^ b_sh_q[0]));
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      a_sh_q  <= '0;
      b_sh_q  <= '0;
      work_q  <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      c_out_q <= 1'b0;
      ovf_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      a_sh_q  <= a_sh_d;
      b_sh_q  <= b_sh_d;
      work_q  <= work_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      c_out_q <= c_out_d;
      ovf_q   <= ovf_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    a_sh_d  = a_sh_q;
    b_sh_d  = b_sh_q;
    work_d  = work_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    c_out_d = c_out_q;
    ovf_d   = ovf_q;
    cnt_d   = cnt_q;

    unique case (state_q)
      S_IDLE, S_DONE: begin
        // DONE accepts a new request exactly like IDLE so requests can
        // run back to back; otherwise DONE lasts a single cycle.
        if (bus.start) begin
          a_sh_d  = bus.a;
          b_sh_d  = bus.b;
          carry_d = bus.c_in;
          work_d  = '0;
          cnt_d   = '0;
          state_d = S_ADD;
        end else begin
          state_d = S_IDLE;
        end
      end

      S_ADD: begin
        // Sum bits enter at the MSB end; after WIDTH shifts the first
        // (LSB) sum bit has reached bit 0.
        work_d  = {cell_s, work_q[WIDTH-1:1]};
        a_sh_d  = {1'b0, a_sh_q[WIDTH-1:1]};
        b_sh_d  = {1'b0, b_sh_q[WIDTH-1:1]};
        carry_d = cell_co;
        cnt_d   = cnt_q + 1'b1;
        if (cnt_q == LAST_BIT) begin
          sum_d   = {cell_s, work_q[WIDTH-1:1]};
          c_out_d = cell_co;
          // carry_q is the carry into the MSB on this final bit.
          ovf_d   = carry_q ^ cell_co;
          cnt_d   = '0;
          state_d = S_DONE;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign bus.busy  = (state_q == S_ADD);
  assign bus.done  = (state_q == S_DONE);
  assign bus.sum   = sum_q;
  assign bus.c_out = c_out_q;
  assign bus.ovf   = ovf_q;

endmodule
